// File: rtl/pc_redirect_ctrl_pkg.sv
// ============================================================================
// Module      : pc_redirect_ctrl_pkg
// Description : Shared PC opcodes, redirect-kind encoding and exception vector
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_redirect_ctrl_pkg;

    localparam logic [3:0] PC_OP_NORMAL = 4'd0;
    localparam logic [3:0] PC_OP_BEQ    = 4'd1;
    localparam logic [3:0] PC_OP_JAL    = 4'd2;
    localparam logic [3:0] PC_OP_JR     = 4'd3;
    localparam logic [3:0] PC_OP_ERET   = 4'd4;
    localparam logic [3:0] PC_OP_BOTBR  = 4'd5;
    localparam logic [3:0] PC_OP_HOLD   = 4'd15;

    localparam logic [2:0] KIND_BEQ   = 3'd1;
    localparam logic [2:0] KIND_JAL   = 3'd2;
    localparam logic [2:0] KIND_JR    = 3'd3;
    localparam logic [2:0] KIND_ERET  = 3'd4;
    localparam logic [2:0] KIND_BOTBR = 3'd5;

    localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

    function automatic logic is_valid_kind(input logic [2:0] kind);
        return (kind >= KIND_BEQ) && (kind <= KIND_BOTBR);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with increment enable, saturating at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (en && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
// ============================================================================
// Module      : pc_redirect_ctrl
// Description : Fetch PC sequencer - redirect deferral, exception entry, flush
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_redirect_ctrl
    import pc_redirect_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [2:0]       redir_kind,
    input  logic [31:0]      redir_target,
    input  logic             exc_req,
    output logic [3:0]       pc_op,
    output logic [31:0]      pc_tgt,
    output logic             pc_req,
    output logic             flush_if,
    output logic             pending,
    output logic [CNT_W-1:0] redir_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_EXC  = 2'd2
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    state_t      state_q, state_d;
    logic [2:0]  kind_q, kind_d;
    logic [31:0] tgt_q, tgt_d;
    logic [2:0]  fcnt_q, fcnt_d;
    logic        cnt_inc;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        tgt_d    = tgt_q;
        fcnt_d   = fcnt_q;
        cnt_inc  = 1'b0;
        pc_req   = 1'b0;
        flush_if = 1'b0;
        pc_op    = stall ? PC_OP_HOLD : PC_OP_NORMAL;
        pc_tgt   = (state_q == ST_PEND) ? tgt_q : 32'd0;

        if (exc_req) begin
            // Exception wins in every state and drops any held redirect.
            pc_req   = 1'b1;
            flush_if = 1'b1;
            pc_op    = PC_OP_HOLD;
            state_d  = ST_EXC;
            fcnt_d   = FLUSH_LOAD;
            kind_d   = 3'd0;
            tgt_d    = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (redir_valid && is_valid_kind(redir_kind)) begin
                        if (stall) begin
                            pc_op   = PC_OP_HOLD;
                            kind_d  = redir_kind;
                            tgt_d   = redir_target;
                            state_d = ST_PEND;
                        end else begin
                            pc_op   = {1'b0, redir_kind};
                            pc_tgt  = redir_target;
                            cnt_inc = 1'b1;
                        end
                    end
                end
                ST_PEND: begin
                    if (!stall) begin
                        pc_op   = {1'b0, kind_q};
                        pc_tgt  = tgt_q;
                        cnt_inc = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_EXC: begin
                    flush_if = 1'b1;
                    if (fcnt_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        fcnt_d = fcnt_q - 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            kind_q  <= 3'd0;
            tgt_q   <= 32'd0;
            fcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            tgt_q   <= tgt_d;
            fcnt_q  <= fcnt_d;
        end
    end

    assign pending = (state_q == ST_PEND);

    sat_counter #(
        .W (CNT_W)
    ) u_redir_cnt (
        .clk   (clk),
        .rst_n (reset),
        .en    (cnt_inc),
        .count (redir_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
// ============================================================================
// Module      : tb_pc_redirect_ctrl
// Description : Directed self-checking bench for pc_redirect_ctrl
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_redirect_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [2:0]  redir_kind;
    logic [31:0] redir_target;
    logic        exc_req;

    logic [3:0]  pc_op,    pc_op4;
    logic [31:0] pc_tgt,   pc_tgt4;
    logic        pc_req,   pc_req4;
    logic        flush_if, flush_if4;
    logic        pending,  pending4;
    logic [15:0] redir_cnt;
    logic [3:0]  redir_cnt4;

    int errors = 0;
    int checks = 0;

    pc_redirect_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_kind   (redir_kind),
        .redir_target (redir_target),
        .exc_req      (exc_req),
        .pc_op        (pc_op),
        .pc_tgt       (pc_tgt),
        .pc_req       (pc_req),
        .flush_if     (flush_if),
        .pending      (pending),
        .redir_cnt    (redir_cnt)
    );

    pc_redirect_ctrl #(
        .FLUSH_CYCLES (2),
        .CNT_W        (4)
    ) dut4 (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_kind   (redir_kind),
        .redir_target (redir_target),
        .exc_req      (exc_req),
        .pc_op        (pc_op4),
        .pc_tgt       (pc_tgt4),
        .pc_req       (pc_req4),
        .flush_if     (flush_if4),
        .pending      (pending4),
        .redir_cnt    (redir_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic v, input logic [2:0] k,
                         input logic [31:0] t, input logic e);
        stall        = s;
        redir_valid  = v;
        redir_kind   = k;
        redir_target = t;
        exc_req      = e;
        #1;
    endtask

    initial begin
        int exp4;
        reset = 1'b0;
        drive(0, 0, 3'd0, 32'd0, 0);

        check("rst_pc_op",    32'(pc_op),     32'd0);
        check("rst_pc_tgt",   pc_tgt,         32'd0);
        check("rst_pc_req",   32'(pc_req),    32'd0);
        check("rst_flush",    32'(flush_if),  32'd0);
        check("rst_pending",  32'(pending),   32'd0);
        check("rst_cnt",      32'(redir_cnt), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // Live JAL
        drive(0, 1, 3'd2, 32'h0000_3040, 0);
        check("jal_pc_op",  32'(pc_op), 32'd2);
        check("jal_pc_tgt", pc_tgt,     32'h0000_3040);
        check("jal_flush",  32'(flush_if), 32'd0);
        tick();
        drive(0, 0, 3'd0, 32'd0, 0);
        check("jal_cnt",    32'(redir_cnt), 32'd1);
        check("idle_pc_op", 32'(pc_op),     32'd0);

        // Stalled JR held for three cycles
        drive(1, 1, 3'd3, 32'h0000_3100, 0);
        check("jr_stall0_op", 32'(pc_op), 32'd15);
        tick();
        check("jr_stall1_op",  32'(pc_op),   32'd15);
        check("jr_stall1_pend", 32'(pending), 32'd1);
        tick();
        check("jr_stall2_op",  32'(pc_op),   32'd15);
        check("jr_stall2_pend", 32'(pending), 32'd1);
        check("jr_stall2_cnt", 32'(redir_cnt), 32'd1);
        tick();
        drive(0, 1, 3'd3, 32'h0000_3100, 0);
        check("jr_rel_op",  32'(pc_op), 32'd3);
        check("jr_rel_tgt", pc_tgt,     32'h0000_3100);
        tick();
        drive(0, 0, 3'd0, 32'd0, 0);
        check("jr_after_pend", 32'(pending),   32'd0);
        check("jr_after_cnt",  32'(redir_cnt), 32'd2);

        // Exception while a redirect is pending
        drive(1, 1, 3'd2, 32'h0000_3200, 0);
        tick();
        check("exc_pend",     32'(pending), 32'd1);
        check("exc_pend_tgt", pc_tgt,       32'h0000_3200);
        drive(1, 0, 3'd0, 32'd0, 1);
        check("exc_req0",   32'(pc_req),   32'd1);
        check("exc_flush0", 32'(flush_if), 32'd1);
        check("exc_op0",    32'(pc_op),    32'd15);
        tick();
        drive(0, 1, 3'd1, 32'h0000_0010, 0);
        check("exc_flush1", 32'(flush_if), 32'd1);
        check("exc_op1",    32'(pc_op),    32'd0);
        check("exc_req1",   32'(pc_req),   32'd0);
        check("exc_pend1",  32'(pending),  32'd0);
        tick();
        check("exc_flush2", 32'(flush_if), 32'd1);
        check("exc_op2",    32'(pc_op),    32'd0);
        tick();
        drive(0, 0, 3'd0, 32'd0, 0);
        check("exc_flush3", 32'(flush_if),  32'd0);
        check("exc_tgt3",   pc_tgt,         32'd0);
        check("exc_cnt3",   32'(redir_cnt), 32'd2);

        // Back-to-back exceptions restart the flush window
        drive(0, 0, 3'd0, 32'd0, 1);
        check("b2b_req0", 32'(pc_req), 32'd1);
        tick();
        check("b2b_req1",   32'(pc_req),   32'd1);
        check("b2b_flush1", 32'(flush_if), 32'd1);
        tick();
        drive(0, 0, 3'd0, 32'd0, 0);
        check("b2b_flush2", 32'(flush_if), 32'd1);
        tick();
        check("b2b_flush3", 32'(flush_if), 32'd1);
        tick();
        check("b2b_flush4", 32'(flush_if), 32'd0);

        // Async reset between edges while PEND
        drive(1, 1, 3'd3, 32'h0000_3300, 0);
        tick();
        check("ar_pend_before", 32'(pending), 32'd1);
        drive(0, 0, 3'd0, 32'd0, 0);
        reset = 1'b0;
        #1;
        check("ar_pend",  32'(pending),   32'd0);
        check("ar_op",    32'(pc_op),     32'd0);
        check("ar_tgt",   pc_tgt,         32'd0);
        check("ar_cnt",   32'(redir_cnt), 32'd0);
        check("ar_flush", 32'(flush_if),  32'd0);
        #1;
        reset = 1'b1;
        drive(0, 1, 3'd4, 32'h0000_0080, 0);
        check("ar_eret_op",  32'(pc_op), 32'd4);
        check("ar_eret_tgt", pc_tgt,     32'h0000_0080);
        tick();
        drive(0, 1, 3'd6, 32'h0000_0abc, 0);
        check("ar_eret_cnt", 32'(redir_cnt), 32'd1);
        check("bad_kind_op",  32'(pc_op), 32'd0);
        check("bad_kind_tgt", pc_tgt,     32'd0);
        tick();
        check("bad_kind_cnt", 32'(redir_cnt), 32'd1);

        // Saturation on the 4-bit counter
        exp4 = 1;
        check("sat_start", 32'(redir_cnt4), 32'(exp4));
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 3'd1, 32'h0000_0010, 0);
            check("sat_op", 32'(pc_op4), 32'd1);
            tick();
            exp4 = (exp4 < 15) ? exp4 + 1 : 15;
            check("sat_cnt", 32'(redir_cnt4), 32'(exp4));
        end
        drive(0, 0, 3'd0, 32'd0, 0);
        check("sat_final", 32'(redir_cnt4), 32'd15);
        check("wide_cnt",  32'(redir_cnt),  32'd21);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
